vga_sync_gen: RTL and testbench

- Generates the raster timing that sprite drawers and ROM-backed pixel sources consume.
- Outputs are hcount/vcount, hsync/vsync, the active-video window, a pixel-rate enable and a frame-start strobe.
- Sits between the board clock and every drawer/compositor in the display path; it is the producer end of the hcount/vcount interface.
- Default timing: 640x480@60 from 50 MHz, one pixel per 2 clocks.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_sync_gen_if.sv | 21 ++
 rtl/pixel_tick_gen.sv | 28 ++
 rtl/vga_sync_gen.sv | 107 ++++++++++
 tb/tb_vga_sync_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the display path.
// Holds the default 640x480@60 timing, the coordinate width and the line/frame total helper.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: vga_sync_gen drives it (master), drawers and compositors consume it (slave).
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               pixel_tick;
    logic               frame_start;

    modport master (
        output hcount, vcount, hsync, vsync, video_on, pixel_tick, frame_start
    );

    modport slave (
        input hcount, vcount, hsync, vsync, video_on, pixel_tick, frame_start
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Clock-per-pixel divider: pixel_tick is high on the last clock of each pixel.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Gated by reset so CLK_DIV=1 does not tick while held in reset.
    assign pixel_tick = reset && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: hcount/vcount counters, sync/active-window decode and frame strobe.
// Optional macro VGA_SYNC_PIPE_ALIGN_EN delays hsync/vsync/video_on by one pixel.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL    = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL    = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START   = H_ACTIVE + H_FP;
    localparam int HS_END     = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START   = V_ACTIVE + V_FP;
    localparam int VS_END     = V_ACTIVE + V_FP + V_SYNC;

    if (H_TOTAL > 2**COORD_W || V_TOTAL > 2**COORD_W || CLK_DIV < 1) begin : g_bad_cfg
        $error("vga_sync_gen: timing totals must fit in COORD_W bits and CLK_DIV must be >= 1");
    end

    logic               pixel_tick;
    logic [COORD_W-1:0] hcount_q;
    logic [COORD_W-1:0] vcount_q;
    logic               frame_start_q;
    logic               h_last;
    logic               v_last;
    logic               hsync_dec;
    logic               vsync_dec;
    logic               video_on_dec;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (pixel_tick)
    );

    assign h_last = (int'(hcount_q) == H_TOTAL - 1);
    assign v_last = (int'(vcount_q) == V_TOTAL - 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pixel_tick && h_last && v_last;
            if (pixel_tick) begin
                if (h_last) begin
                    hcount_q <= '0;
                    vcount_q <= v_last ? '0 : vcount_q + COORD_W'(1);
                end else begin
                    hcount_q <= hcount_q + COORD_W'(1);
                end
            end
        end
    end

    assign hsync_dec    = !((int'(hcount_q) >= HS_START) && (int'(hcount_q) < HS_END));
    assign vsync_dec    = !((int'(vcount_q) >= VS_START) && (int'(vcount_q) < VS_END));
    assign video_on_dec = (int'(hcount_q) < H_ACTIVE) && (int'(vcount_q) < V_ACTIVE);

`ifdef VGA_SYNC_PIPE_ALIGN_EN
    logic hsync_q;
    logic vsync_q;
    logic video_on_q;

    // Captures the decode of the pixel being left, so outputs trail the counters by one pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else if (pixel_tick) begin
            hsync_q    <= hsync_dec;
            vsync_q    <= vsync_dec;
            video_on_q <= video_on_dec;
        end
    end

    assign vga.hsync    = hsync_q || !reset;
    assign vga.vsync    = vsync_q || !reset;
    assign vga.video_on = video_on_q && reset;
`else
    assign vga.hsync    = hsync_dec || !reset;
    assign vga.vsync    = vsync_dec || !reset;
    assign vga.video_on = video_on_dec && reset;
`endif

    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.pixel_tick  = pixel_tick;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing instance plus a tiny CLK_DIV=1 instance
// that makes full-frame behaviour (vsync window, frame_start period) reachable in a short run.
`define CHK(tag, obs, exp) \
    begin \
        logic [31:0] o_; \
        logic [31:0] e_; \
        o_ = 32'(obs); \
        e_ = 32'(exp); \
        n_assert++; \
        assert (o_ === e_) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0d expected=%0d", tag, o_, e_); \
        end \
    end

module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIPE_ALIGN_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    // Small instance timing: H 8/2/3/2 = 15, V 4/1/2/1 = 8, one clock per pixel -> 120-clock frame.
    localparam int S_FRAME = 15 * 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset_s = 1'b0;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if vga ();
    vga_sync_gen_if vga_s ();

    vga_sync_gen u_dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vga)
    );

    vga_sync_gen #(
        .CLK_DIV  (1),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) u_small (
        .clk   (clk),
        .reset (reset_s),
        .vga   (vga_s)
    );

    initial begin
        int  hs_cnt, hs_first, hs_last, vo_cnt, vo_last, vs_line_low, holds, prev_h;
        bit  seen_end, found;
        int  fs_cnt, fs_first, fs_last, bad_gap, wide, tick_low, vs_low, vs_out, fs_pos_bad;
        bit  fs_prev, vwin;
        int  sh, sv;

        // Both instances held in reset for 5 clocks.
        repeat (5) begin
            @(negedge clk);
            `CHK("rst_hcount", vga.hcount, 0)
            `CHK("rst_vcount", vga.vcount, 0)
            `CHK("rst_hsync", vga.hsync, 1)
            `CHK("rst_vsync", vga.vsync, 1)
            `CHK("rst_video_on", vga.video_on, 0)
            `CHK("rst_pixel_tick", vga.pixel_tick, 0)
            `CHK("rst_frame_start", vga.frame_start, 0)
            `CHK("rst_small_pixel_tick", vga_s.pixel_tick, 0)
        end

        reset = 1'b1;
        @(negedge clk);
        `CHK("first_tick", vga.pixel_tick, 1)
        `CHK("first_tick_hcount", vga.hcount, 0)
        `CHK("h0_video_on", vga.video_on, (LAG == 0) ? 1 : 0)
        @(negedge clk);
        `CHK("after_first_tick_hcount", vga.hcount, 1)
        `CHK("after_first_tick_pixel_tick", vga.pixel_tick, 0)

        // One full line, sampled once per pixel on its tick clock.
        hs_cnt = 0; hs_first = -1; hs_last = -1; vo_cnt = 0; vo_last = -1;
        vs_line_low = 0; holds = 0; prev_h = 1; seen_end = 1'b0;
        for (int i = 0; i < 1700 && !seen_end; i++) begin
            @(negedge clk);
            if (vga.pixel_tick) begin
                if (int'(vga.hcount) != prev_h) holds++;
                if (!vga.hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(vga.hcount);
                    hs_last = int'(vga.hcount);
                end
                if (vga.video_on) begin
                    vo_cnt++;
                    vo_last = int'(vga.hcount);
                end
                if (!vga.vsync) vs_line_low++;
                if (vga.hcount == 10'd799) seen_end = 1'b1;
            end
            prev_h = int'(vga.hcount);
        end
        `CHK("line_end_reached", seen_end, 1)
        `CHK("hsync_low_ticks", hs_cnt, 96)
        `CHK("hsync_first_low_h", hs_first, 656 + LAG)
        `CHK("hsync_last_low_h", hs_last, 751 + LAG)
        `CHK("video_on_ticks", vo_cnt, 639 + LAG)
        `CHK("video_on_last_h", vo_last, 639 + LAG)
        `CHK("vsync_low_on_line0", vs_line_low, 0)
        `CHK("hold_between_ticks", holds, 0)

        @(negedge clk);
        `CHK("wrap_hcount", vga.hcount, 0)
        `CHK("wrap_vcount", vga.vcount, 1)
        `CHK("wrap_no_frame_start", vga.frame_start, 0)

        // Mid-line reset pulse at hcount=300 on line 1.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (vga.hcount == 10'd300) found = 1'b1;
        end
        `CHK("reach_h300", found, 1)
        `CHK("reach_h300_vcount", vga.vcount, 1)
        reset = 1'b0;
        @(negedge clk);
        `CHK("midrst_hcount", vga.hcount, 0)
        `CHK("midrst_vcount", vga.vcount, 0)
        `CHK("midrst_frame_start", vga.frame_start, 0)
        `CHK("midrst_hsync", vga.hsync, 1)
        `CHK("midrst_video_on", vga.video_on, 0)
        `CHK("midrst_pixel_tick", vga.pixel_tick, 0)
        reset = 1'b1;
        @(negedge clk);
        `CHK("resume_frame_start", vga.frame_start, 0)
        `CHK("resume_tick", vga.pixel_tick, 1)
        `CHK("resume_hcount0", vga.hcount, 0)
        @(negedge clk);
        `CHK("resume_hcount1", vga.hcount, 1)
        `CHK("resume_vcount", vga.vcount, 0)
        repeat (2) @(negedge clk);
        `CHK("resume_hcount2", vga.hcount, 2)

        // Small CLK_DIV=1 instance: three full frames.
        reset_s = 1'b1;
        fs_cnt = 0; fs_first = -1; fs_last = 0; bad_gap = 0; wide = 0; tick_low = 0;
        vs_low = 0; vs_out = 0; fs_pos_bad = 0; fs_prev = 1'b0;
        for (int i = 1; i <= 3 * S_FRAME + 10; i++) begin
            @(negedge clk);
            sh = int'(vga_s.hcount);
            sv = int'(vga_s.vcount);
            if (!vga_s.pixel_tick) tick_low++;
            if (vga_s.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                else if (i - fs_last != S_FRAME) bad_gap++;
                if (sh != 0 || sv != 0) fs_pos_bad++;
                fs_last = i;
                if (fs_prev) wide++;
            end
            fs_prev = vga_s.frame_start;
            if (LAG == 0) vwin = (sv >= 5 && sv <= 6);
            else          vwin = (sv >= 5 && sv <= 6 && sh != 0) || (sv == 7 && sh == 0);
            if (i <= S_FRAME && !vga_s.vsync) vs_low++;
            if (!vga_s.vsync && !vwin) vs_out++;
        end
        `CHK("small_tick_always_high", tick_low, 0)
        `CHK("small_first_frame_start", fs_first, S_FRAME)
        `CHK("small_frame_start_count", fs_cnt, 3)
        `CHK("small_frame_period", bad_gap, 0)
        `CHK("small_frame_start_width", wide, 0)
        `CHK("small_frame_start_at_origin", fs_pos_bad, 0)
        `CHK("small_vsync_low_pixels", vs_low, 30)
        `CHK("small_vsync_outside_window", vs_out, 0)

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`undef CHK
